// File: rtl/digital_freq_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : digital_freq_counter
// Purpose  : Gated BCD pulse counter driving a 6-digit multiplexed display.
// Revision : 1.0 - initial release
// ============================================================================
module digital_freq_counter #(
    parameter int GATE_CYCLES    = 50_000_000,
    parameter int REFRESH_CYCLES = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freq_in,
    output logic [23:0] hex_display,
    output logic [6:0]  segment_output,
    output logic [5:0]  anode_common,
    output logic [2:0]  led_status
);

    localparam int c_GATE_W = $clog2(GATE_CYCLES);
    localparam int c_REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [c_GATE_W-1:0] c_GATE_LAST = c_GATE_W'(GATE_CYCLES - 1);
    localparam logic [c_REF_W-1:0]  c_REF_LAST  = c_REF_W'(REFRESH_CYCLES - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    logic                w_edge;

    logic [c_GATE_W-1:0] r_gate_cnt;
    logic                w_gate_end;

    logic [23:0]         r_count;
    logic                r_ovf;
    logic [23:0]         w_count_inc;
    logic [23:0]         w_count_next;
    logic                w_ovf_next;
    logic                w_carry;

    logic [23:0]         r_hex;
    logic [2:0]          r_led;

    logic [c_REF_W-1:0]  r_ref_cnt;
    logic [2:0]          r_digit_idx;
    logic [5:0]          r_anode;
    logic [6:0]          r_seg;
    logic [3:0]          w_nibble;
    logic [6:0]          w_glyph;

    // Two-flop synchronizer plus one history flop for rising-edge detect.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= freq_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge     = r_sync2 & ~r_prev;
    assign w_gate_end = (r_gate_cnt == c_GATE_LAST);

    // Ripple BCD increment; a carry out of the top digit means 999999 saturates.
    always_comb begin
        w_count_inc = r_count;
        w_carry     = w_edge;
        for (int i = 0; i < 6; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
        w_count_next = w_carry ? r_count : w_count_inc;
        w_ovf_next   = r_ovf | w_carry;
    end

    // The latch takes the next-count value so an edge in the closing cycle is kept.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_gate_cnt <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_hex      <= '0;
            r_led      <= 3'b000;
        end else if (w_gate_end) begin
            r_gate_cnt <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_hex      <= w_count_next;
            r_led[2]   <= w_ovf_next;
            r_led[1]   <= 1'b1;
            r_led[0]   <= ~r_led[0];
        end else begin
            r_gate_cnt <= r_gate_cnt + c_GATE_W'(1);
            r_count    <= w_count_next;
            r_ovf      <= w_ovf_next;
        end
    end

    always_comb begin
        w_nibble = 4'hF;
        case (r_digit_idx)
            3'd0:    w_nibble = r_hex[3:0];
            3'd1:    w_nibble = r_hex[7:4];
            3'd2:    w_nibble = r_hex[11:8];
            3'd3:    w_nibble = r_hex[15:12];
            3'd4:    w_nibble = r_hex[19:16];
            3'd5:    w_nibble = r_hex[23:20];
            default: w_nibble = 4'hF;
        endcase
    end

    always_comb begin
        w_glyph = 7'b1111111;
        case (w_nibble)
            4'd0:    w_glyph = 7'b1000000;
            4'd1:    w_glyph = 7'b1111001;
            4'd2:    w_glyph = 7'b0100100;
            4'd3:    w_glyph = 7'b0110000;
            4'd4:    w_glyph = 7'b0011001;
            4'd5:    w_glyph = 7'b0010010;
            4'd6:    w_glyph = 7'b0000010;
            4'd7:    w_glyph = 7'b1111000;
            4'd8:    w_glyph = 7'b0000000;
            4'd9:    w_glyph = 7'b0010000;
            default: w_glyph = 7'b1111111;
        endcase
    end

    // Anode and segments are registered together from the same index.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ref_cnt   <= '0;
            r_digit_idx <= 3'd0;
            r_anode     <= 6'b111110;
            r_seg       <= 7'b1000000;
        end else begin
            if (r_ref_cnt == c_REF_LAST) begin
                r_ref_cnt   <= '0;
                r_digit_idx <= (r_digit_idx == 3'd5) ? 3'd0 : r_digit_idx + 3'd1;
            end else begin
                r_ref_cnt   <= r_ref_cnt + c_REF_W'(1);
            end
            r_anode <= ~(6'b000001 << r_digit_idx);
            r_seg   <= w_glyph;
        end
    end

    assign hex_display    = r_hex;
    assign led_status     = r_led;
    assign anode_common   = r_anode;
    assign segment_output = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_digital_freq_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_digital_freq_counter
// Purpose  : Directed and random pulse windows checked against an integer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digital_freq_counter;

    localparam int GATE = 1000;
    localparam int REF  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freq_in;
    logic [23:0] hex_display;
    logic [6:0]  segment_output;
    logic [5:0]  anode_common;
    logic [2:0]  led_status;

    int checks  = 0;
    int errors  = 0;
    int windows = 0;

    localparam logic [6:0] GLYPHS [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    digital_freq_counter #(
        .GATE_CYCLES    (GATE),
        .REFRESH_CYCLES (REF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .freq_in        (freq_in),
        .hex_display    (hex_display),
        .segment_output (segment_output),
        .anode_common   (anode_common),
        .led_status     (led_status)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        if (d > 4'd9) return 7'b1111111;
        return GLYPHS[d];
    endfunction

    // Watches the scan: after the first observed digit change, the digit must
    // advance by one every REF cycles and show the right glyph.
    task automatic check_mux(input int cycles, input logic [23:0] hexv);
        int first, cur, dwell, idx;
        logic [5:0] exp_an;
        first = -1;
        cur   = -1;
        dwell = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (cur < 0) begin
                idx = -1;
                for (int b = 5; b >= 0; b--) if (anode_common[b] == 1'b0) idx = b;
                if (first < 0) first = idx;
                else if (idx != first) begin
                    cur   = (first + 1) % 6;
                    dwell = 1;
                end
            end else begin
                dwell++;
                if (dwell > REF) begin
                    cur   = (cur + 1) % 6;
                    dwell = 1;
                end
            end
            if (cur >= 0) begin
                exp_an = ~(6'b000001 << cur);
                chk("mux anode", anode_common, exp_an);
                chk("mux seg", segment_output, glyph(hexv[4*cur +: 4]));
            end
        end
        chk("mux sync", cur >= 0, 1);
    endtask

    // Runs exactly one gate window starting just after a latch edge, pulses
    // placed well inside it, then checks the latched result.
    task automatic run_window(input string tag, input int base, input int n,
                              input int h, input int l, input bit mux,
                              input logic [23:0] mux_hex);
        int elapsed, total;
        logic [23:0] exp_hex;
        elapsed = 0;
        if (mux) begin
            check_mux(30, mux_hex);
            elapsed += 30;
        end
        repeat (5) begin @(negedge clk); elapsed++; end
        for (int p = 0; p < n; p++) begin
            freq_in = 1'b1;
            repeat (h) begin @(negedge clk); elapsed++; end
            freq_in = 1'b0;
            repeat (l) begin @(negedge clk); elapsed++; end
        end
        while (elapsed < GATE) begin @(negedge clk); elapsed++; end
        windows++;
        total   = base + n;
        exp_hex = to_bcd(total > 999999 ? 999999 : total);
        chk({tag, " hex"}, hex_display, exp_hex);
        chk({tag, " led"}, led_status, {total > 999999, 1'b1, windows[0]});
    endtask

    initial begin
        int n, h, l;
        rst_n   = 1'b1;
        freq_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset hex", hex_display, 24'h000000);
        chk("reset led", led_status, 3'b000);
        chk("reset anode", anode_common, 6'b111110);
        chk("reset seg", segment_output, 7'b1000000);
        rst_n = 1'b0;

        run_window("idle", 0, 0, 1, 1, 1'b0, 24'h0);
        run_window("single", 0, 1, 1, 3, 1'b0, 24'h0);
        run_window("ten", 0, 10, 2, 2, 1'b0, 24'h0);
        run_window("sixtyfour", 0, 64, 2, 2, 1'b0, 24'h0);
        run_window("fresh", 0, 0, 1, 1, 1'b1, 24'h000064);

        force dut.r_count = 24'h999998;
        #1;
        release dut.r_count;
        run_window("overflow", 999998, 3, 2, 2, 1'b0, 24'h0);
        run_window("clean", 0, 0, 1, 1, 1'b0, 24'h0);

        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(0, 150);
            h = $urandom_range(1, 3);
            l = $urandom_range(1, 3);
            run_window("random", 0, n, h, l, 1'b0, 24'h0);
        end

        // Partial window cut short by reset must be discarded.
        repeat (20) begin
            freq_in = 1'b1; repeat (2) @(negedge clk);
            freq_in = 1'b0; repeat (2) @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset hex", hex_display, 24'h000000);
        chk("midreset led", led_status, 3'b000);
        rst_n   = 1'b0;
        windows = 0;
        n = $urandom_range(1, 100);
        run_window("after reset", 0, n, 1, 2, 1'b0, 24'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digital_freq_counter.md
Name: digital_freq_counter

Overview:
- Measures the frequency of an external pulse input by counting its rising edges during a fixed gate window of system-clock cycles.
- At the end of each window, latches the count as a 6-digit BCD value.
- Drives a multiplexed 6-digit common-anode seven-segment display and three status LEDs.
- Sits at the board I/O boundary, between an external signal pin and the front-panel display.

Parameters:
- GATE_CYCLES, 50_000_000, clk cycles per gate window (1 s at 50 MHz); minimum 16.
- REFRESH_CYCLES, 50_000, clk cycles each display digit is lit (1 ms); minimum 1.

Ports:
- clk  input  1  system clock, 50 MHz, rising-edge.
- rst_n  input  1  synchronous reset, active-high (asserted when 1), sampled on rising clk.
- freq_in  input  1  asynchronous measured signal.
- hex_display  output  24  latched result, 6 BCD digits; [3:0] is units, [23:20] is hundred-thousands.
- segment_output  output  7  segments {g,f,e,d,c,b,a}, active-low.
- anode_common  output  6  digit enables, one-hot active-low; bit i selects digit i.
- led_status  output  3  [0] gate-window toggle, [1] result valid, [2] overflow.

Behaviour:
Reset (rst_n=1 at a clk edge):
- Clears hex_display to 0, led_status to 3'b000, the edge counter, the gate timer and the mux index.
- Sets anode_common to 6'b111110 and segment_output to 7'b1000000 (glyph "0").

Input conditioning:
- freq_in passes through a 2-flop synchronizer, then a third flop for edge detection.
- A rising edge is counted when sync=1 and the previous sample was 0.
- Input-to-count latency is 3 clk cycles.
- Pulses with high or low time shorter than 1 clk period may be missed; this is not an error.

Counting:
- The counter is a 6-digit cascaded BCD counter that increments by 1 per detected edge.
- Each digit wraps 9 to 0 with a carry into the next digit.
- When the counter reads 999999 and another edge arrives, it holds at 999999 and sets an internal overflow flag.

Gate window:
- The gate timer counts 0..GATE_CYCLES-1 and wraps.
- On the cycle where the timer equals GATE_CYCLES-1:
  - hex_display latches the counter value, including any edge detected in that same cycle.
  - led_status[2] latches the overflow flag.
  - led_status[1] is set to 1 and stays 1 until reset.
  - led_status[0] toggles.
  - The counter and overflow flag clear to 0 on the next cycle, so no edge is lost or double-counted.
- hex_display and led_status[2] are stable between latches.
- An edge arriving in the same cycle as the latch counts in the closing window.
- Asserting reset mid-window discards the partial count. The first window after reset release is a full GATE_CYCLES long.

Display multiplexing:
- A refresh counter advances the digit index 0..5 every REFRESH_CYCLES, wrapping 5 to 0.
- anode_common drives low only the bit equal to the index.
- segment_output is the decoded hex_display digit at that index, registered, in the same cycle as the anode.
- Glyph patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Non-BCD nibbles, which cannot occur, display blank (1111111).
- Leading zeros are displayed.

Test Plan:
- Reset held 2 cycles, freq_in=0, GATE_CYCLES=100 -> after 1 window hex_display=24'h000000, led_status=3'b011, anode_common=6'b111110.
- One 20 ns high pulse within window, GATE_CYCLES=100 -> next latch hex_display=24'h000001, led_status[2]=0.
- 10 pulses, each 40 ns high / 40 ns low, inside one window -> hex_display=24'h000010.
- 64 pulses, 40 ns high / 40 ns low, GATE_CYCLES=1000 -> hex_display=24'h000064. Then with a fresh window and no pulses -> 24'h000000.
- Overflow: force the counter to 999998 by hierarchical deposit, then apply 3 edges -> hex_display=24'h999999, led_status[2]=1. Next clean window -> led_status[2]=0.
- Mux with REFRESH_CYCLES=2 and hex_display=24'h000064 -> anode_common cycles 111110, 111101, ..., 011111 every 2 clk. segment_output shows 0011001 ("4") with digit 0, 0000010 ("6") with digit 1, and 1000000 ("0") with the others.
